// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder sequencer: one shared single-digit BCD stage, LSD first.
// Optional macro BCD_SUB_EN adds a 'sub' port for ten's-complement subtraction.

module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] d,
  output logic       cout
);
  logic [4:0] s;
  logic [3:0] s_cor;

  always_comb begin
    s     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    s_cor = s[3:0] + 4'd6;
    cout  = (s > 5'd9);
    d     = cout ? s_cor : s[3:0];
  end
endmodule

module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
`ifdef BCD_SUB_EN
  input  logic                sub,
`endif
  input  logic [4*DIGITS-1:0] op_a,
  input  logic [4*DIGITS-1:0] op_b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                carry_out,
  output logic                err
);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DIGITS-1:0][3:0]  a_q, b_q, sum_q;
  logic [CNT_W-1:0]        idx;
  logic                    carry;
  logic                    accept, last, op_err, carry_init;
  logic [3:0]              a_dig, b_dig, b_eff, d;
  logic                    c_nxt;

  assign accept = start && (state != ADD);
  assign last   = (idx == CNT_W'(DIGITS-1));
  assign busy   = (state == ADD);
  assign done   = (state == DONE);
  assign sum    = sum_q;

  always_comb begin
    a_dig  = '0;
    b_dig  = '0;
    op_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == CNT_W'(i)) begin
        a_dig = a_q[i];
        b_dig = b_q[i];
      end
      if (op_a[4*i+:4] > 4'd9 || op_b[4*i+:4] > 4'd9) op_err = 1'b1;
    end
  end

`ifdef BCD_SUB_EN
  logic sub_q;
  // nines' complement of B plus an initial carry of one gives A + (10^N - B)
  assign b_eff      = sub_q ? (4'd9 - b_dig) : b_dig;
  assign carry_init = sub;
`else
  assign b_eff      = b_dig;
  assign carry_init = 1'b0;
`endif

  bcd_digit_add u_dig (
    .a   (a_dig),
    .b   (b_eff),
    .cin (carry),
    .d   (d),
    .cout(c_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? ADD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      carry_out <= 1'b0;
      err       <= 1'b0;
`ifdef BCD_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else if (accept) begin
      a_q       <= op_a;
      b_q       <= op_b;
      sum_q     <= '0;
      idx       <= '0;
      carry     <= carry_init;
      carry_out <= 1'b0;
      err       <= op_err;
`ifdef BCD_SUB_EN
      sub_q     <= sub;
`endif
    end else if (state == ADD) begin
      for (int i = 0; i < DIGITS; i++)
        if (idx == CNT_W'(i)) sum_q[i] <= d;
      carry <= c_nxt;
      idx   <= idx + CNT_W'(1);
      if (last) carry_out <= c_nxt;
    end
  end
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl: vector table + decimal reference model feeding a scoreboard,
// plus directed sequences for timing, ignored start, back-to-back, invalid digits and reset.

module tb_bcd_serial_add_ctrl;
  localparam int DIGITS = 4;
  localparam int W      = 4*DIGITS;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         busy, done, carry_out, err;
  logic [W-1:0] sum;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef BCD_SUB_EN
    .sub(sub),
`endif
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .sum(sum), .carry_out(carry_out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         s;
    logic [W-1:0] exp_sum;
    logic         exp_c, exp_err, chk;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         c, err, chk;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0, errors = 0, done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard consumer: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (e.chk) begin
          check("sum", sum, e.sum);
          check("carry_out", carry_out, e.c);
        end
        check("err", err, e.err);
      end
    end
  end

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS-1; i >= 0; i--) r = r*10 + int'(v[4*i+:4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // decimal reference: modulus 10^DIGITS, carry = overflow (or no-borrow for subtraction)
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   m = 1, r;
    for (int i = 0; i < DIGITS; i++) m *= 10;
    r = s ? bcd2int(a) - bcd2int(b) + m : bcd2int(a) + bcd2int(b);
    e.sum = int2bcd(r % m);
    e.c   = (r >= m);
    e.err = 1'b0;
    e.chk = 1'b1;
    return e;
  endfunction

  task automatic push(input logic [W-1:0] es, input logic ec, input logic ee, input logic chk);
    exp_t e;
    e.sum = es; e.c = ec; e.err = ee; e.chk = chk;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 3*DIGITS+2 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", 3*DIGITS+2);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] es, input logic ec, input logic ee, input logic chk);
    drive(a, b, s);
    push(es, ec, ee, chk);
    @(negedge clk);
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom);   // late operand changes must not matter
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    int d0;
    exp_t e;
    logic [W-1:0] ra, rb;

    vecs.push_back('{16'h0005, 16'h0008, 1'b0, 16'h0013, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{16'h9999, 16'h9999, 1'b0, 16'h9998, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{16'h4567, 16'h1111, 1'b0, 16'h5678, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{16'h00A0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{16'h1234, 16'hF000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0});
`ifdef BCD_SUB_EN
    vecs.push_back('{16'h0051, 16'h0009, 1'b1, 16'h0042, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{16'h0009, 16'h0051, 1'b1, 16'h9958, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{16'h1000, 16'h1000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1});
`endif

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_carry", carry_out, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // latency and busy window: busy in cycles k..k+3, done only in k+4
    drive(16'h0005, 16'h0008, 1'b0);
    push(16'h0013, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("sum_cleared_in_add", sum, 0);
    for (int i = 0; i < DIGITS; i++) begin
      check("busy_window", busy, 1);
      check("no_early_done", done, 0);
      @(negedge clk);
    end
    check("done_at_k_plus_n", done, 1);
    check("busy_low_at_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // table vectors
    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp_sum, vecs[i].exp_c,
             vecs[i].exp_err, vecs[i].chk);

    // random valid operands against the decimal model
    for (int n = 0; n < 8; n++) begin
      for (int d = 0; d < DIGITS; d++) begin
        ra[4*d+:4] = 4'($urandom_range(9));
        rb[4*d+:4] = 4'($urandom_range(9));
      end
`ifdef BCD_SUB_EN
      e = model(ra, rb, n[0]);
      run_op(ra, rb, n[0], e.sum, e.c, 1'b0, 1'b1);
`else
      e = model(ra, rb, 1'b0);
      run_op(ra, rb, 1'b0, e.sum, e.c, 1'b0, 1'b1);
`endif
    end

    // err visible from accept, held in IDLE, cleared by next valid start
    drive(16'h00A0, 16'h0000, 1'b0);
    push(16'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("err_at_accept", err, 1);
    wait_done();
    @(negedge clk);
    check("err_held_idle", err, 1);
    drive(16'h0002, 16'h0003, 1'b0);
    push(16'h0005, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("err_cleared", err, 0);
    wait_done();
    @(negedge clk);

    // start during busy is ignored
    d0 = done_cnt;
    drive(16'h1111, 16'h2222, 1'b0);
    push(16'h3333, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op_a = 16'h9999; op_b = 16'h9999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (DIGITS+2) @(negedge clk);
    check("ignored_start_one_done", done_cnt - d0, 1);

    // start held through DONE: second op accepted without idle gap
    drive(16'h0123, 16'h0456, 1'b0);
    push(16'h0579, 1'b0, 1'b0, 1'b1);
    wait_done();
    op_a = 16'h0700; op_b = 16'h0400;
    push(16'h1100, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_no_done", done, 0);
    wait_done();
    @(negedge clk);

    // reset mid-ADD aborts without a done pulse
    d0 = done_cnt;
    drive(16'h1A11, 16'h2222, 1'b0);
    push(16'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_err", err, 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_carry", carry_out, 0);
    check("mid_rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DIGITS+3) @(negedge clk);
    check("no_done_after_rst", done_cnt - d0, 0);
    run_op(16'h0048, 16'h0052, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1);
  end
endmodule
